stw_column_tester: RTL and testbench
====================================

// Module: stw_column_tester
// PURPOSE
//  Per-column stationary-weight self-test (STW) engine; sits directly upstream of the column's proxy controller.
//  Drives LFSR test weights/activations into one systolic column, checks every PE's partial sum and
//  publishes a per-row pass mask (1 = good, 0 = faulty) plus a completion flag that the proxy controller consumes.
// PARAMETERS
//  ROWS            4        PEs in the column; width of result mask
//  COL_IDX         0        column served (informational; no effect on logic)
//  WORD_SIZE       16       datapath width, must be <= 16
//  NUM_PATTERNS    4        test patterns per run, >= 1
//  RESULT_LATENCY  ROWS+1   cycles from activation drive until pe_psum_bus is valid, >= 1
//  LFSR_SEED       16'hACE1 LFSR value loaded at each run start, must be nonzero
// PORTS
//  clk             in   1                clock, rising edge
//  rst             in   1                asynchronous, active-low reset
//  stw_start       in   1                start request; sampled only in IDLE or DONE
//  pe_psum_bus     in   ROWS*WORD_SIZE   bottom_out of each PE; row r at [r*WORD_SIZE +: WORD_SIZE]
//  stw_weight_out  out  WORD_SIZE        test weight broadcast to the column
//  stw_load_weight out  1                column latches stw_weight_out as stationary weight
//  stw_left_out    out  WORD_SIZE        test activation driven into every row's left_in
//  stw_left_valid  out  1                stw_left_out valid
//  stw_busy        out  1                run in progress (LOAD..CHECK)
//  STW_complete    out  1                run finished, mask valid
//  STW_result_mat  out  ROWS             pass mask to proxy controller
// BEHAVIOUR
//  Reset (async, rst=0): state IDLE; STW_result_mat all ones; STW_complete, stw_busy, stw_load_weight,
//   stw_left_valid 0; stw_weight_out, stw_left_out 0; LFSR = LFSR_SEED; pattern and wait counters 0.
//   Reset during a run aborts it and discards the partial mask.
//  FSM: IDLE -start-> LOAD -> DRIVE -> WAIT (RESULT_LATENCY cycles) -> CHECK -> LOAD (more patterns) | DONE.
//   DONE -start-> LOAD. In IDLE/DONE with stw_start=0 the state holds.
//  Start edge: reload LFSR with LFSR_SEED, clear pattern counter, set running mask to all ones, drop STW_complete.
//  LOAD (1 cycle): stw_load_weight=1, stw_weight_out = lfsr[WORD_SIZE-1:0].
//  DRIVE (1 cycle): stw_left_valid=1, stw_left_out = {lfsr[7:0],lfsr[15:8]}[WORD_SIZE-1:0] with bit0 forced to 1.
//  WAIT: counter counts RESULT_LATENCY cycles; outputs return to 0.
//  CHECK (1 cycle): p = (w*l) mod 2^WORD_SIZE; prev(0)=0, prev(r)=psum[r-1];
//   row r passes iff (psum[r]-prev(r)) mod 2^WORD_SIZE == p; run_mask[r] &= pass[r].
//   Localises faults: a bad PE0 does not fail PE1..ROWS-1. LFSR advances one step
//   (Fibonacci, taps 16,14,13,11; shift left, feedback into bit0); pattern counter increments.
//  After pattern NUM_PATTERNS-1 CHECK -> DONE: STW_result_mat <= run_mask, STW_complete <= 1 (level, held).
//  STW_result_mat changes only on entry to DONE; it holds its previous value during a run.
//  stw_busy = 1 in LOAD, DRIVE, WAIT, CHECK.
//  stw_start while busy is ignored (no restart, no queuing).
//  Latency: DONE is entered on the NUM_PATTERNS*(3+RESULT_LATENCY)-th rising edge after the edge that samples
//   stw_start (defaults: 32).
//  In DONE, stw_start=1 restarts immediately: STW_complete falls on the same edge that enters LOAD.
// CONFIGURATION
//  STW_STICKY_MASK_EN defined: on DONE, STW_result_mat <= STW_result_mat & run_mask. Faults accumulate
//   across runs and clear only on reset.
//  Undefined: STW_result_mat <= run_mask. Each run fully replaces the prior mask.
// TESTING
//  1 Fault-free column model, pulse start -> stw_busy for 32 cycles; STW_complete=1; STW_result_mat=4'b1111.
//  2 PE2 bottom_out stuck-at 16'h0000 -> mask 4'b1011 (PE3 stays good via difference check).
//  3 PE0 adds +1 to its psum -> mask 4'b1110; four weight/left pairs match the LFSR sequence from 16'hACE1.
//  4 stw_start pulsed at cycle 10 of a run -> ignored; completion timing unchanged (edge 32).
//  5 rst low at cycle 15 -> outputs return to reset values immediately, mask 4'b1111; a new start completes normally.
//  6 STW_STICKY_MASK_EN: run 1 fails PE1 (4'b1101), run 2 fault-free -> mask stays 4'b1101;
//    without the macro the mask becomes 4'b1111.

Source files
------------

// File: rtl/stw_column_tester.sv
// stw_column_tester: per-column stationary-weight self-test engine.
// Drives LFSR test weight/activation pairs into one systolic column, checks each
// PE's contribution by differencing adjacent partial sums, and publishes a pass mask.
// Optional feature macro: STW_STICKY_MASK_EN (faults accumulate across runs until reset).
module stw_column_tester #(
    parameter int          ROWS           = 4,
    parameter int          COL_IDX        = 0,
    parameter int          WORD_SIZE      = 16,
    parameter int          NUM_PATTERNS   = 4,
    parameter int          RESULT_LATENCY = ROWS + 1,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stw_start,
    input  logic [ROWS*WORD_SIZE-1:0] pe_psum_bus,
    output logic [WORD_SIZE-1:0]      stw_weight_out,
    output logic                      stw_load_weight,
    output logic [WORD_SIZE-1:0]      stw_left_out,
    output logic                      stw_left_valid,
    output logic                      stw_busy,
    output logic                      STW_complete,
    output logic [ROWS-1:0]           STW_result_mat
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_DRIVE, S_WAIT, S_CHECK, S_DONE
    } state_t;

    localparam logic [15:0] WAIT_LAST = 16'(RESULT_LATENCY - 1);
    localparam logic [15:0] PAT_LAST  = 16'(NUM_PATTERNS - 1);

    // Parameter sanity; COL_IDX only identifies the column and never alters logic.
    if (WORD_SIZE > 16 || WORD_SIZE < 2 || NUM_PATTERNS < 1 || RESULT_LATENCY < 1 ||
        LFSR_SEED == 16'h0000 || COL_IDX < 0) begin : g_bad_cfg
        $error("stw_column_tester: illegal parameter combination");
    end

    state_t              state_q, state_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [15:0]         pat_q, pat_d;
    logic [15:0]         wait_q, wait_d;
    logic [ROWS-1:0]     run_mask_q, run_mask_d;
    logic [ROWS-1:0]     result_q, result_d;
    logic                complete_q, complete_d;

    logic [15:0]         lfsr_swapped;
    logic [WORD_SIZE-1:0] test_w, test_l, expect_p;
    logic [ROWS-1:0]     row_pass;
    logic [ROWS-1:0]     final_mask;
    logic                lfsr_fb;

    // The LFSR is stable from LOAD through CHECK, so the same pair is recomputed at CHECK.
    assign lfsr_swapped = {lfsr_q[7:0], lfsr_q[15:8]};
    assign test_w       = lfsr_q[WORD_SIZE-1:0];
    assign test_l       = {lfsr_swapped[WORD_SIZE-1:1], 1'b1};
    assign expect_p     = test_w * test_l;
    assign lfsr_fb      = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign final_mask   = run_mask_q & row_pass;

    // Each row is judged on its own contribution: psum[r] - psum[r-1] must equal w*l.
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        logic [WORD_SIZE-1:0] cur_psum, prev_psum;
        assign cur_psum = pe_psum_bus[gi*WORD_SIZE +: WORD_SIZE];
        if (gi == 0) begin : g_first
            assign prev_psum = '0;
        end else begin : g_rest
            assign prev_psum = pe_psum_bus[(gi-1)*WORD_SIZE +: WORD_SIZE];
        end
        assign row_pass[gi] = ((cur_psum - prev_psum) == expect_p);
    end

    // Column drive outputs decode directly from the current state.
    assign stw_load_weight = (state_q == S_LOAD);
    assign stw_weight_out  = (state_q == S_LOAD) ? test_w : '0;
    assign stw_left_valid  = (state_q == S_DRIVE);
    assign stw_left_out    = (state_q == S_DRIVE) ? test_l : '0;
    assign stw_busy        = (state_q == S_LOAD) || (state_q == S_DRIVE) ||
                             (state_q == S_WAIT) || (state_q == S_CHECK);
    assign STW_complete    = complete_q;
    assign STW_result_mat  = result_q;

    // State, LFSR, counters and masks; reset aborts any run in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            lfsr_q     <= LFSR_SEED;
            pat_q      <= '0;
            wait_q     <= '0;
            run_mask_q <= '1;
            result_q   <= '1;
            complete_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            pat_q      <= pat_d;
            wait_q     <= wait_d;
            run_mask_q <= run_mask_d;
            result_q   <= result_d;
            complete_q <= complete_d;
        end
    end

    // Next-state logic: sequencing of patterns and mask accumulation.
    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        pat_d      = pat_q;
        wait_d     = wait_q;
        run_mask_d = run_mask_q;
        result_d   = result_q;
        complete_d = complete_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (stw_start) begin
                    state_d    = S_LOAD;
                    lfsr_d     = LFSR_SEED;
                    pat_d      = '0;
                    run_mask_d = '1;
                    complete_d = 1'b0;
                end
            end
            S_LOAD: state_d = S_DRIVE;
            S_DRIVE: begin
                state_d = S_WAIT;
                wait_d  = '0;
            end
            S_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = S_CHECK;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            S_CHECK: begin
                run_mask_d = final_mask;
                lfsr_d     = {lfsr_q[14:0], lfsr_fb};
                pat_d      = pat_q + 16'd1;
                if (pat_q == PAT_LAST) begin
                    state_d    = S_DONE;
                    complete_d = 1'b1;
`ifdef STW_STICKY_MASK_EN
                    result_d   = result_q & final_mask;
`else
                    result_d   = final_mask;
`endif
                end else begin
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_stw_column_tester.sv
// Self-checking bench for stw_column_tester: behavioural systolic column with
// injectable PE faults, LFSR pattern table and published-mask model.
module tb_stw_column_tester;

    localparam int ROWS = 4;
    localparam int W    = 16;
    localparam int NP   = 4;
    localparam int RL   = ROWS + 1;
    localparam int RUN_CYCLES = NP * (3 + RL);

    logic              clk = 1'b0;
    logic              rst;
    logic              stw_start;
    logic [ROWS*W-1:0] pe_psum_bus;
    logic [W-1:0]      stw_weight_out;
    logic              stw_load_weight;
    logic [W-1:0]      stw_left_out;
    logic              stw_left_valid;
    logic              stw_busy;
    logic              STW_complete;
    logic [ROWS-1:0]   STW_result_mat;

    int checks   = 0;
    int failures = 0;

    logic [15:0]     exp_w [NP];
    logic [15:0]     exp_l [NP];
    logic [ROWS-1:0] exp_result;
    int              fault_kind [ROWS];   // 0 good, 1 stuck-at-0, 2 adds offset
    logic [15:0]     fault_off  [ROWS];

    stw_column_tester #(
        .ROWS(ROWS), .COL_IDX(0), .WORD_SIZE(W), .NUM_PATTERNS(NP),
        .RESULT_LATENCY(RL), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst(rst), .stw_start(stw_start), .pe_psum_bus(pe_psum_bus),
        .stw_weight_out(stw_weight_out), .stw_load_weight(stw_load_weight),
        .stw_left_out(stw_left_out), .stw_left_valid(stw_left_valid),
        .stw_busy(stw_busy), .STW_complete(STW_complete), .STW_result_mat(STW_result_mat)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    task automatic clear_faults();
        for (int r = 0; r < ROWS; r++) begin
            fault_kind[r] = 0;
            fault_off[r]  = 16'h0;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        stw_start = 1'b0;
        pe_psum_bus = '0;
        @(negedge clk);
        rst = 1'b1;
        exp_result = '1;
    endtask

    // One full run: pulse start, act as the column, check drive values, timing and mask.
    task automatic do_run(input string name, input int poke_cycle);
        int              cyc;
        int              pidx;
        logic [15:0]     w_cur, p, acc, outv;
        logic [ROWS-1:0] rm;
        rm = '1; pidx = 0; w_cur = 16'h0;
        @(negedge clk); stw_start = 1'b1;
        @(negedge clk); stw_start = 1'b0;
        checks++;
        if (STW_complete !== 1'b0 || stw_busy !== 1'b1) begin
            failures++;
            $display("FAIL %s_start: complete=%b busy=%b required complete=0 busy=1", name, STW_complete, stw_busy);
        end
        cyc = 0;
        while (stw_busy === 1'b1 && cyc < 200) begin
            if (stw_load_weight === 1'b1) begin
                checks++;
                if (pidx >= NP || stw_weight_out !== exp_w[pidx % NP]) begin
                    failures++;
                    $display("FAIL %s_weight%0d: got %h required %h", name, pidx, stw_weight_out, exp_w[pidx % NP]);
                end
                w_cur = stw_weight_out;
            end else begin
                checks++;
                if (stw_weight_out !== 16'h0) begin
                    failures++;
                    $display("FAIL %s_weight_idle: got %h required 0000", name, stw_weight_out);
                end
            end
            if (stw_left_valid === 1'b1) begin
                checks++;
                if (pidx >= NP || stw_left_out !== exp_l[pidx % NP]) begin
                    failures++;
                    $display("FAIL %s_left%0d: got %h required %h", name, pidx, stw_left_out, exp_l[pidx % NP]);
                end
                p = w_cur * stw_left_out;
                acc = 16'h0;
                for (int r = 0; r < ROWS; r++) begin
                    outv = acc + p;
                    if (fault_kind[r] == 1) outv = 16'h0;
                    else if (fault_kind[r] == 2) outv = outv + fault_off[r];
                    pe_psum_bus[r*W +: W] = outv;
                    if (16'(outv - acc) !== p) rm[r] = 1'b0;
                    acc = outv;
                end
                pidx++;
            end
            checks++;
            if (STW_result_mat !== exp_result) begin
                failures++;
                $display("FAIL %s_mask_hold: got %b required %b", name, STW_result_mat, exp_result);
            end
            stw_start = (cyc == poke_cycle) ? 1'b1 : 1'b0;
            cyc++;
            @(negedge clk);
        end
        stw_start = 1'b0;
        checks++;
        if (cyc != RUN_CYCLES || pidx != NP) begin
            failures++;
            $display("FAIL %s_busy_cycles: got %0d cycles %0d patterns required %0d cycles %0d patterns", name, cyc, pidx, RUN_CYCLES, NP);
        end
`ifdef STW_STICKY_MASK_EN
        exp_result = exp_result & rm;
`else
        exp_result = rm;
`endif
        checks++;
        if (STW_complete !== 1'b1 || STW_result_mat !== exp_result) begin
            failures++;
            $display("FAIL %s_done: complete=%b mask=%b required complete=1 mask=%b", name, STW_complete, STW_result_mat, exp_result);
        end
        @(negedge clk);
        checks++;
        if (STW_complete !== 1'b1 || stw_busy !== 1'b0 || STW_result_mat !== exp_result) begin
            failures++;
            $display("FAIL %s_done_hold: complete=%b busy=%b mask=%b required 1 0 %b", name, STW_complete, stw_busy, STW_result_mat, exp_result);
        end
        $display("run %s: cycles=%0d mask=%b expected=%b", name, cyc, STW_result_mat, exp_result);
    endtask

    task automatic test_reset();
        rst = 1'b0; stw_start = 1'b0; pe_psum_bus = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (STW_result_mat !== 4'b1111 || STW_complete !== 1'b0 || stw_busy !== 1'b0 ||
            stw_load_weight !== 1'b0 || stw_left_valid !== 1'b0 ||
            stw_weight_out !== 16'h0 || stw_left_out !== 16'h0) begin
            failures++;
            $display("FAIL reset_values: mask=%b cmp=%b busy=%b ld=%b lv=%b w=%h l=%h required 1111 0 0 0 0 0000 0000",
                     STW_result_mat, STW_complete, stw_busy, stw_load_weight, stw_left_valid, stw_weight_out, stw_left_out);
        end
        rst = 1'b1;
        exp_result = '1;
        repeat (3) @(negedge clk);
        checks++;
        if (stw_busy !== 1'b0 || STW_complete !== 1'b0) begin
            failures++;
            $display("FAIL idle_hold: busy=%b complete=%b required 0 0", stw_busy, STW_complete);
        end
    endtask

    task automatic test_fault_free();
        apply_reset(); clear_faults();
        do_run("fault_free", -1);
        checks++;
        if (STW_result_mat !== 4'b1111) begin
            failures++;
            $display("FAIL fault_free_mask: got %b required 1111", STW_result_mat);
        end
    endtask

    task automatic test_pe2_stuck();
        apply_reset(); clear_faults();
        fault_kind[2] = 1;
        do_run("pe2_stuck0", -1);
        checks++;
        if (STW_result_mat !== 4'b1011) begin
            failures++;
            $display("FAIL pe2_stuck_mask: got %b required 1011", STW_result_mat);
        end
    endtask

    task automatic test_pe0_plus1();
        apply_reset(); clear_faults();
        fault_kind[0] = 2; fault_off[0] = 16'h0001;
        do_run("pe0_plus1", -1);
        checks++;
        if (STW_result_mat !== 4'b1110) begin
            failures++;
            $display("FAIL pe0_plus1_mask: got %b required 1110", STW_result_mat);
        end
    endtask

    task automatic test_start_while_busy();
        apply_reset(); clear_faults();
        do_run("start_while_busy", 10);
        checks++;
        if (STW_result_mat !== 4'b1111) begin
            failures++;
            $display("FAIL start_while_busy_mask: got %b required 1111", STW_result_mat);
        end
    endtask

    task automatic test_reset_midrun();
        apply_reset(); clear_faults();
        fault_kind[1] = 2; fault_off[1] = 16'h0040;
        @(negedge clk); stw_start = 1'b1;
        @(negedge clk); stw_start = 1'b0;
        repeat (15) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (STW_result_mat !== 4'b1111 || STW_complete !== 1'b0 || stw_busy !== 1'b0 ||
            stw_load_weight !== 1'b0 || stw_left_valid !== 1'b0 ||
            stw_weight_out !== 16'h0 || stw_left_out !== 16'h0) begin
            failures++;
            $display("FAIL reset_midrun: mask=%b cmp=%b busy=%b ld=%b lv=%b w=%h l=%h required 1111 0 0 0 0 0000 0000",
                     STW_result_mat, STW_complete, stw_busy, stw_load_weight, stw_left_valid, stw_weight_out, stw_left_out);
        end
        @(negedge clk); rst = 1'b1;
        exp_result = '1;
        clear_faults();
        do_run("after_abort", -1);
        checks++;
        if (STW_result_mat !== 4'b1111) begin
            failures++;
            $display("FAIL after_abort_mask: got %b required 1111", STW_result_mat);
        end
    endtask

    task automatic test_sticky();
        apply_reset(); clear_faults();
        fault_kind[1] = 2; fault_off[1] = 16'h0005;
        do_run("sticky_run1", -1);
        checks++;
        if (STW_result_mat !== 4'b1101) begin
            failures++;
            $display("FAIL sticky_run1_mask: got %b required 1101", STW_result_mat);
        end
        clear_faults();
        do_run("sticky_run2", -1);
        checks++;
`ifdef STW_STICKY_MASK_EN
        if (STW_result_mat !== 4'b1101) begin
            failures++;
            $display("FAIL sticky_run2_mask: got %b required 1101", STW_result_mat);
        end
`else
        if (STW_result_mat !== 4'b1111) begin
            failures++;
            $display("FAIL sticky_run2_mask: got %b required 1111", STW_result_mat);
        end
`endif
    endtask

    // Back-to-back restarts from DONE with random fault placements.
    task automatic test_random_back_to_back();
        apply_reset();
        for (int n = 0; n < 8; n++) begin
            for (int r = 0; r < ROWS; r++) begin
                fault_kind[r] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
                fault_off[r]  = 16'($urandom_range(1, 65535));
            end
            do_run($sformatf("random%0d", n), -1);
        end
    endtask

    initial begin
        logic [15:0] s;
        s = 16'hACE1;
        for (int i = 0; i < NP; i++) begin
            exp_w[i] = s;
            exp_l[i] = {s[7:0], s[15:8]} | 16'h0001;
            s = lfsr_next(s);
        end
        clear_faults();
        test_reset();
        test_fault_free();
        test_pe2_stuck();
        test_pe0_plus1();
        test_start_while_busy();
        test_reset_midrun();
        test_sticky();
        test_random_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
